// File: rtl/mcctrl_pkg.sv
// Shared definitions for the multicycle CPU controller: state encoding,
// opcode constants and datapath mux/ALU encodings.
// Optional feature macro: MCCTRL_JUMP_EN (adds the JUMP state).
package mcctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_EXEC    = 4'd6,
    ST_RWB     = 4'd7,
    ST_BRANCH  = 4'd8,
`ifdef MCCTRL_JUMP_EN
    ST_JUMP    = 4'd9,
`endif
    ST_ORIEX   = 4'd10,
    ST_ORIWB   = 4'd11,
    ST_ILLEGAL = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  // States that talk to memory and therefore wait on the handshake
  function automatic logic is_mem_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/mcctrl_memwait.sv
// Memory wait counter: counts cycles spent in the current memory state,
// saturating at MEM_WAIT, and flags handshake completion once the minimum
// wait has elapsed and mem_ready is high.
module mcctrl_memwait #(
  parameter int MEM_WAIT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_active,
  input  logic i_mem_ready,
  output logic o_done
);

  localparam logic [3:0] LP_LIMIT = 4'(MEM_WAIT);

  logic [3:0] r_cnt;
  logic       w_at_limit;

  assign w_at_limit = (r_cnt == LP_LIMIT);
  // Held low during reset so no strobe can fire while rst_n is asserted.
  assign o_done = rst_n & i_active & w_at_limit & i_mem_ready;

  // Counter restarts whenever a memory state is left or not occupied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (!i_active || o_done) begin
      r_cnt <= 4'd0;
    end else if (!w_at_limit) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/mcctrl_fsm.sv
// Multicycle CPU main controller (Moore FSM).
// Optional feature macro: MCCTRL_JUMP_EN (opcode 000010 handled as jump;
// without it that opcode is treated as illegal).
//
// state   | meaning
// FETCH   | read instruction, PC+4; strobes on handshake complete
// DECODE  | register read, branch target computed
// MEMADR  | effective address for lw/sw
// MEMRD   | data memory read, waits for handshake
// MEMWB   | load result written to register file
// MEMWR   | data memory write, waits for handshake
// EXEC    | R-type ALU operation
// RWB     | R-type result written back
// BRANCH  | beq compare, conditional PC update
// JUMP    | unconditional PC update (MCCTRL_JUMP_EN only)
// ORIEX   | ori with zero-extended immediate
// ORIWB   | ori result written back
// ILLEGAL | one-cycle illegal-opcode flag
module mcctrl_fsm
  import mcctrl_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int OPC_W    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic             ori_zext,
  output logic             illegal,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state
);

  state_e r_state;
  logic   w_mem_active;
  logic   w_done;
  logic   w_unused;

  // zero goes straight to the datapath branch logic, gated there by pc_write_cond.
  assign w_unused     = zero;
  assign w_mem_active = is_mem_state(r_state);
  assign state        = r_state;

  mcctrl_memwait #(
    .MEM_WAIT(MEM_WAIT)
  ) u_memwait (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_active   (w_mem_active),
    .i_mem_ready(mem_ready),
    .o_done     (w_done)
  );

  // State register and transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
    end else begin
      case (r_state)
        ST_FETCH:  if (w_done) r_state <= ST_DECODE;
        ST_DECODE: begin
          case (opcode)
            OP_RTYPE:     r_state <= ST_EXEC;
            OP_LW, OP_SW: r_state <= ST_MEMADR;
            OP_BEQ:       r_state <= ST_BRANCH;
            OP_ORI:       r_state <= ST_ORIEX;
`ifdef MCCTRL_JUMP_EN
            OP_J:         r_state <= ST_JUMP;
`endif
            default:      r_state <= ST_ILLEGAL;
          endcase
        end
        ST_MEMADR: r_state <= (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
        ST_MEMRD:  if (w_done) r_state <= ST_MEMWB;
        ST_MEMWB:  r_state <= ST_FETCH;
        ST_MEMWR:  if (w_done) r_state <= ST_FETCH;
        ST_EXEC:   r_state <= ST_RWB;
        ST_RWB:    r_state <= ST_FETCH;
        ST_BRANCH: r_state <= ST_FETCH;
`ifdef MCCTRL_JUMP_EN
        ST_JUMP:   r_state <= ST_FETCH;
`endif
        ST_ORIEX:  r_state <= ST_ORIWB;
        ST_ORIWB:  r_state <= ST_FETCH;
        default:   r_state <= ST_FETCH;
      endcase
    end
  end

  // Output decode from state, with FETCH strobes qualified by the handshake.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    ori_zext      = 1'b0;
    illegal       = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    pc_source     = PCS_ALU;
    case (r_state)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = w_done;
        pc_write  = w_done;
      end
      ST_DECODE: alu_src_b = SRCB_BOFF;
      ST_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      ST_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      ST_RWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCS_ALUOUT;
      end
`ifdef MCCTRL_JUMP_EN
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCS_JUMP;
      end
`endif
      ST_ORIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_OR;
        ori_zext  = 1'b1;
      end
      ST_ORIWB: begin
        reg_write = 1'b1;
        ori_zext  = 1'b1;
      end
      ST_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mcctrl_fsm.sv
// Directed bench for mcctrl_fsm: three instances with MEM_WAIT = 0, 2, 3
// share clock, reset and inputs; each step compares one instance's full
// output word against a hand-written expected word.
module tb_mcctrl_fsm;

  localparam logic [11:0] F_PCW  = 12'h800;
  localparam logic [11:0] F_PWC  = 12'h400;
  localparam logic [11:0] F_IORD = 12'h200;
  localparam logic [11:0] F_MRD  = 12'h100;
  localparam logic [11:0] F_MWR  = 12'h080;
  localparam logic [11:0] F_IRW  = 12'h040;
  localparam logic [11:0] F_M2R  = 12'h020;
  localparam logic [11:0] F_RDST = 12'h010;
  localparam logic [11:0] F_REGW = 12'h008;
  localparam logic [11:0] F_SRCA = 12'h004;
  localparam logic [11:0] F_ORI  = 12'h002;
  localparam logic [11:0] F_ILL  = 12'h001;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       pc_write [3];
  logic       pc_write_cond [3];
  logic       i_or_d [3];
  logic       mem_read [3];
  logic       mem_write [3];
  logic       ir_write [3];
  logic       mem_to_reg [3];
  logic       reg_dst [3];
  logic       reg_write [3];
  logic       alu_src_a [3];
  logic       ori_zext [3];
  logic       illegal [3];
  logic [1:0] alu_src_b [3];
  logic [1:0] alu_op [3];
  logic [1:0] pc_source [3];
  logic [3:0] st [3];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mcctrl_fsm #(
      .MEM_WAIT((g == 0) ? 0 : ((g == 1) ? 2 : 3)),
      .OPC_W(6)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .opcode       (opcode),
      .zero         (zero),
      .mem_ready    (mem_ready),
      .pc_write     (pc_write[g]),
      .pc_write_cond(pc_write_cond[g]),
      .i_or_d       (i_or_d[g]),
      .mem_read     (mem_read[g]),
      .mem_write    (mem_write[g]),
      .ir_write     (ir_write[g]),
      .mem_to_reg   (mem_to_reg[g]),
      .reg_dst      (reg_dst[g]),
      .reg_write    (reg_write[g]),
      .alu_src_a    (alu_src_a[g]),
      .ori_zext     (ori_zext[g]),
      .illegal      (illegal[g]),
      .alu_src_b    (alu_src_b[g]),
      .alu_op       (alu_op[g]),
      .pc_source    (pc_source[g]),
      .state        (st[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [3:0] s, input logic [11:0] f,
                                     input logic [1:0] b, input logic [1:0] op,
                                     input logic [1:0] src);
    return {10'd0, s, f, b, op, src};
  endfunction

  function automatic logic [31:0] obs(input int k);
    return {10'd0, st[k], pc_write[k], pc_write_cond[k], i_or_d[k], mem_read[k],
            mem_write[k], ir_write[k], mem_to_reg[k], reg_dst[k], reg_write[k],
            alu_src_a[k], ori_zext[k], illegal[k], alu_src_b[k], alu_op[k],
            pc_source[k]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%06h expected=%06h", tag, o, e);
    end
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  logic [31:0] W_FETCH, W_FETCH_DONE, W_DECODE, W_MEMADR, W_MEMRD, W_MEMWB;
  logic [31:0] W_MEMWR, W_EXEC, W_RWB, W_BRANCH, W_JUMP, W_ORIEX, W_ORIWB, W_ILLEGAL;

  initial begin
    W_FETCH      = mk(4'd0,  F_MRD,                 2'b01, 2'b00, 2'b00);
    W_FETCH_DONE = mk(4'd0,  F_MRD | F_IRW | F_PCW, 2'b01, 2'b00, 2'b00);
    W_DECODE     = mk(4'd1,  12'h000,               2'b11, 2'b00, 2'b00);
    W_MEMADR     = mk(4'd2,  F_SRCA,                2'b10, 2'b00, 2'b00);
    W_MEMRD      = mk(4'd3,  F_MRD | F_IORD,        2'b00, 2'b00, 2'b00);
    W_MEMWB      = mk(4'd4,  F_REGW | F_M2R,        2'b00, 2'b00, 2'b00);
    W_MEMWR      = mk(4'd5,  F_MWR | F_IORD,        2'b00, 2'b00, 2'b00);
    W_EXEC       = mk(4'd6,  F_SRCA,                2'b00, 2'b10, 2'b00);
    W_RWB        = mk(4'd7,  F_RDST | F_REGW,       2'b00, 2'b00, 2'b00);
    W_BRANCH     = mk(4'd8,  F_SRCA | F_PWC,        2'b00, 2'b01, 2'b01);
    W_JUMP       = mk(4'd9,  F_PCW,                 2'b00, 2'b00, 2'b10);
    W_ORIEX      = mk(4'd10, F_SRCA | F_ORI,        2'b10, 2'b11, 2'b00);
    W_ORIWB      = mk(4'd11, F_REGW | F_ORI,        2'b00, 2'b00, 2'b00);
    W_ILLEGAL    = mk(4'd12, F_ILL,                 2'b00, 2'b00, 2'b00);

    // Reset with mem_ready already high: FETCH values, strobes held low.
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = 6'b100011;
    #3;
    chk("rst_mw0", obs(0), W_FETCH);
    chk("rst_mw3", obs(2), W_FETCH);

    // lw, MEM_WAIT=0: 0,1,2,3,4,0
    @(negedge clk); rst_n = 1'b1; #1;
    chk("lw_fetch", obs(0), W_FETCH_DONE);
    nxt; chk("lw_decode", obs(0), W_DECODE);
    nxt; chk("lw_memadr", obs(0), W_MEMADR);
    nxt; chk("lw_memrd", obs(0), W_MEMRD);
    nxt; chk("lw_memwb", obs(0), W_MEMWB);
    nxt; chk("lw_fetch2", obs(0), W_FETCH_DONE);

    // sw with a one-cycle stall in MEMWR
    opcode = 6'b101011;
    nxt; chk("sw_decode", obs(0), W_DECODE);
    nxt; chk("sw_memadr", obs(0), W_MEMADR);
    nxt; chk("sw_memwr", obs(0), W_MEMWR);
    mem_ready = 1'b0;
    nxt; chk("sw_memwr_stall", obs(0), W_MEMWR);
    mem_ready = 1'b1;
    nxt; chk("sw_fetch", obs(0), W_FETCH_DONE);

    // ori
    opcode = 6'b001101;
    nxt; chk("ori_decode", obs(0), W_DECODE);
    nxt; chk("ori_ex", obs(0), W_ORIEX);
    nxt; chk("ori_wb", obs(0), W_ORIWB);
    nxt; chk("ori_fetch", obs(0), W_FETCH_DONE);

    // R-type
    opcode = 6'b000000;
    nxt; chk("r_decode", obs(0), W_DECODE);
    nxt; chk("r_exec", obs(0), W_EXEC);
    nxt; chk("r_wb", obs(0), W_RWB);
    nxt; chk("r_fetch", obs(0), W_FETCH_DONE);

    // beq
    opcode = 6'b000100; zero = 1'b1;
    nxt; chk("beq_decode", obs(0), W_DECODE);
    nxt; chk("beq_branch", obs(0), W_BRANCH);
    nxt; chk("beq_fetch", obs(0), W_FETCH_DONE);
    zero = 1'b0;

    // illegal opcode
    opcode = 6'b111111;
    nxt; chk("ill_decode", obs(0), W_DECODE);
    nxt; chk("ill_state", obs(0), W_ILLEGAL);
    nxt; chk("ill_fetch", obs(0), W_FETCH_DONE);

    // jump opcode: JUMP when enabled, ILLEGAL otherwise
    opcode = 6'b000010;
    nxt; chk("j_decode", obs(0), W_DECODE);
    nxt;
`ifdef MCCTRL_JUMP_EN
    chk("j_state", obs(0), W_JUMP);
`else
    chk("j_state", obs(0), W_ILLEGAL);
`endif
    nxt; chk("j_fetch", obs(0), W_FETCH_DONE);

    // MEM_WAIT=2: early mem_ready ignored, strobe at FETCH cycle 2, then hold
    opcode = 6'b001101; mem_ready = 1'b1;
    do_reset;
    chk("mw2_c0", obs(1), W_FETCH);
    nxt; chk("mw2_c1", obs(1), W_FETCH);
    nxt; chk("mw2_c2", obs(1), W_FETCH_DONE);
    mem_ready = 1'b0; #1;
    chk("mw2_drop", obs(1), W_FETCH);
    nxt; chk("mw2_hold1", obs(1), W_FETCH);
    nxt; chk("mw2_hold2", obs(1), W_FETCH);
    mem_ready = 1'b1; #1;
    chk("mw2_ready", obs(1), W_FETCH_DONE);
    nxt; chk("mw2_decode", obs(1), W_DECODE);

    // MEM_WAIT=3: asynchronous reset in the middle of MEMRD
    opcode = 6'b100011; mem_ready = 1'b1;
    do_reset;
    chk("mw3_c0", obs(2), W_FETCH);
    nxt; chk("mw3_c1", obs(2), W_FETCH);
    nxt; chk("mw3_c2", obs(2), W_FETCH);
    nxt; chk("mw3_c3", obs(2), W_FETCH_DONE);
    nxt; chk("mw3_decode", obs(2), W_DECODE);
    nxt; chk("mw3_memadr", obs(2), W_MEMADR);
    nxt; chk("mw3_memrd0", obs(2), W_MEMRD);
    nxt; chk("mw3_memrd1", obs(2), W_MEMRD);
    #1; rst_n = 1'b0; #1;
    chk("mw3_async_rst", obs(2), W_FETCH);
    chk("mw0_async_rst", obs(0), W_FETCH);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("mw3_rel_c0", obs(2), W_FETCH);
    nxt; chk("mw3_rel_c1", obs(2), W_FETCH);
    nxt; chk("mw3_rel_c2", obs(2), W_FETCH);
    nxt; chk("mw3_rel_c3", obs(2), W_FETCH_DONE);
    nxt; chk("mw3_rel_decode", obs(2), W_DECODE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
